// File: rtl/sdram_frame_uart_dump_pkg.sv
// Shared types and constants for the framebuffer UART dump path.
// DUMP_CHECKSUM_EN adds the trailing checksum states.
package frame_dump_pkg;

    localparam int unsigned DefWordCount  = 19220;
    localparam int unsigned DefClksPerBit = 218;
    localparam int unsigned UartFrameBits = 10;

    typedef enum logic [3:0] {
        StIdle,
        StReq,
        StSendLo,
        StWaitLo,
        StSendHi,
        StWaitHi,
`ifdef DUMP_CHECKSUM_EN
        StCsumLo,
        StCsumLoWait,
        StCsumHi,
        StCsumHiWait,
`endif
        StFin
    } dump_state_e;

endpackage

// File: rtl/sdram_frame_uart_dump_if.sv
// SDRAM controller host read port as seen by the dump engine (master) and controller (slave).
interface sdram_frame_uart_dump_if #(
    parameter int unsigned HADDR_WIDTH = 24
) ();
    logic [HADDR_WIDTH-1:0] rd_addr;
    logic                   rd_enable;
    logic                   rd_ready;
    logic [15:0]            rd_data;

    modport master (output rd_addr, output rd_enable, input rd_ready, input rd_data);
    modport slave  (input rd_addr, input rd_enable, output rd_ready, output rd_data);
endinterface

// File: rtl/sdram_frame_uart_dump_uart_tx_core.sv
// UART 8N1 transmitter: one-cycle i_tx_dv loads a byte, o_tx_done pulses in the last stop-bit cycle.
module uart_tx_core
    import frame_dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW = $clog2(UartFrameBits);

    logic                     busy_q, busy_d;
    logic [UartFrameBits-1:0] shift_q, shift_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [BitW-1:0]          bit_q, bit_d;
    logic                     tx_q, tx_d;
    logic                     bit_end;

    always_comb begin
        busy_d    = busy_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        o_tx_done = 1'b0;
        bit_end   = (cnt_q == CntW'(CLKS_PER_BIT - 1));
        if (!busy_q) begin
            if (i_tx_dv) begin
                busy_d  = 1'b1;
                // Whole frame in one register: stop, data LSB first, start.
                shift_d = {1'b1, i_tx_byte, 1'b0};
                cnt_d   = '0;
                bit_d   = '0;
            end
        end else if (bit_end) begin
            cnt_d = '0;
            if (bit_q == BitW'(UartFrameBits - 1)) begin
                busy_d    = 1'b0;
                o_tx_done = 1'b1;
            end else begin
                bit_d   = bit_q + 1'b1;
                shift_d = {1'b1, shift_q[UartFrameBits-1:1]};
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        tx_d = busy_q ? shift_q[0] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            shift_q <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            busy_q  <= busy_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    assign o_tx_serial = tx_q;
    assign o_tx_active = busy_q;

endmodule

// File: rtl/sdram_frame_uart_dump.sv
// Reads WORD_COUNT words from SDRAM and streams each as two UART bytes, low byte first.
// DUMP_CHECKSUM_EN appends a 16-bit running sum of the words as two extra bytes.
module sdram_frame_uart_dump
    import frame_dump_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
    parameter int unsigned WORD_COUNT   = DefWordCount,
    parameter int unsigned START_ADDR   = 0,
    parameter int unsigned HADDR_WIDTH  = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    sdram_frame_uart_dump_if.master        rd_bus,
    output logic                           tx,
    output logic                           active,
    output logic                           done
);
    localparam int unsigned IdxW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

    dump_state_e     state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [15:0]     word_q, word_d;
    logic            rd_enable_q, active_q, done_q;
    logic            byte_dv, core_active, core_done;
    logic [7:0]      tx_byte;
`ifdef DUMP_CHECKSUM_EN
    logic [15:0]     csum_q, csum_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        byte_dv = 1'b0;
        tx_byte = word_q[7:0];
`ifdef DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            StIdle: if (start) begin
                idx_d   = '0;
`ifdef DUMP_CHECKSUM_EN
                csum_d  = '0;
`endif
                state_d = StReq;
            end
            StReq: if (rd_bus.rd_ready) begin
                word_d  = rd_bus.rd_data;
`ifdef DUMP_CHECKSUM_EN
                csum_d  = csum_q + rd_bus.rd_data;
`endif
                state_d = StSendLo;
            end
            StSendLo: if (!core_active) begin
                byte_dv = 1'b1;
                state_d = StWaitLo;
            end
            StWaitLo: if (core_done) state_d = StSendHi;
            StSendHi: if (!core_active) begin
                byte_dv = 1'b1;
                tx_byte = word_q[15:8];
                state_d = StWaitHi;
            end
            StWaitHi: if (core_done) begin
                if (idx_q == IdxW'(WORD_COUNT - 1)) begin
`ifdef DUMP_CHECKSUM_EN
                    state_d = StCsumLo;
`else
                    state_d = StFin;
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StReq;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            StCsumLo: if (!core_active) begin
                byte_dv = 1'b1;
                tx_byte = csum_q[7:0];
                state_d = StCsumLoWait;
            end
            StCsumLoWait: if (core_done) state_d = StCsumHi;
            StCsumHi: if (!core_active) begin
                byte_dv = 1'b1;
                tx_byte = csum_q[15:8];
                state_d = StCsumHiWait;
            end
            StCsumHiWait: if (core_done) state_d = StFin;
`endif
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs lag the state by one cycle, lining up with the registered TX pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            word_q      <= '0;
            rd_enable_q <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            rd_enable_q <= (state_q == StReq);
            active_q    <= (state_q != StIdle) && (state_q != StFin);
            done_q      <= (state_q == StFin);
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end
`endif

    assign rd_bus.rd_addr   = HADDR_WIDTH'(START_ADDR) + HADDR_WIDTH'(idx_q);
    assign rd_bus.rd_enable = rd_enable_q;
    assign active           = active_q;
    assign done             = done_q;

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .i_tx_dv    (byte_dv),
        .i_tx_byte  (tx_byte),
        .o_tx_serial(tx),
        .o_tx_active(core_active),
        .o_tx_done  (core_done)
    );

endmodule

// File: tb/tb_sdram_frame_uart_dump.sv
// Directed bench: single dump, reset values, ignored start, reset mid-byte, address wrap.
module tb_sdram_frame_uart_dump;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic start   = 1'b0;
    logic start_w = 1'b0;
    logic tx, active, done, tx_w, active_w, done_w;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef DUMP_CHECKSUM_EN
    localparam int NBytes = 8;
`else
    localparam int NBytes = 6;
`endif
    logic [7:0] exp_bytes [8] = '{8'h5A, 8'hA5, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h5B, 8'hA4};

    always #5 clk = ~clk;

    sdram_frame_uart_dump_if #(.HADDR_WIDTH(24)) bus ();
    sdram_frame_uart_dump_if #(.HADDR_WIDTH(3))  bus_w ();

    sdram_frame_uart_dump #(
        .CLKS_PER_BIT(4), .WORD_COUNT(3), .START_ADDR(5), .HADDR_WIDTH(24)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rd_bus(bus),
        .tx(tx), .active(active), .done(done)
    );

    sdram_frame_uart_dump #(
        .CLKS_PER_BIT(4), .WORD_COUNT(3), .START_ADDR(6), .HADDR_WIDTH(3)
    ) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .rd_bus(bus_w),
        .tx(tx_w), .active(active_w), .done(done_w)
    );

    function automatic logic [15:0] mem_rd(input logic [23:0] a);
        case (a)
            24'd5:   return 16'hA55A;
            24'd6:   return 16'h0001;
            24'd7:   return 16'hFF00;
            default: return 16'hDEAD;
        endcase
    endfunction

    // Controller models: latch address on request, answer with a one-cycle strobe ~3 cycles later.
    int          addr_log[$];
    int          addr_log_w[$];
    bit          m_busy, mw_busy;
    int          m_lat, mw_lat;
    logic [23:0] m_addr;

    always @(negedge clk) begin
        if (rst) begin
            bus.rd_ready = 1'b0;
            bus.rd_data  = 16'h0;
            m_busy       = 1'b0;
        end else if (bus.rd_ready) begin
            bus.rd_ready = 1'b0;
        end else if (m_busy) begin
            if (m_lat == 0) begin
                bus.rd_ready = 1'b1;
                bus.rd_data  = mem_rd(m_addr);
                m_busy       = 1'b0;
            end else m_lat--;
        end else if (bus.rd_enable === 1'b1) begin
            m_busy = 1'b1;
            m_lat  = 1;
            m_addr = bus.rd_addr;
            addr_log.push_back(int'(bus.rd_addr));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            bus_w.rd_ready = 1'b0;
            bus_w.rd_data  = 16'h0;
            mw_busy        = 1'b0;
        end else if (bus_w.rd_ready) begin
            bus_w.rd_ready = 1'b0;
        end else if (mw_busy) begin
            if (mw_lat == 0) begin
                bus_w.rd_ready = 1'b1;
                bus_w.rd_data  = 16'h1234;
                mw_busy        = 1'b0;
            end else mw_lat--;
        end else if (bus_w.rd_enable === 1'b1) begin
            mw_busy = 1'b1;
            mw_lat  = 1;
            addr_log_w.push_back(int'(bus_w.rd_addr));
        end
    end

    // UART decoder for the main DUT, 4 cycles per bit, sampled mid-bit.
    logic [7:0] dec_bytes[$];
    logic [7:0] dshift;
    bit         dbusy;
    int         dcnt;
    int         frame_err;
    int         done_cnt;

    always @(negedge clk) begin
        if (rst) begin
            dbusy = 1'b0;
        end else if (!dbusy) begin
            if (tx === 1'b0) begin
                dbusy = 1'b1;
                dcnt  = 0;
            end
        end else begin
            dcnt++;
            if (dcnt == 2 && tx !== 1'b0) frame_err++;
            if (dcnt >= 6 && dcnt <= 34 && ((dcnt - 2) % 4) == 0) dshift[(dcnt - 6) / 4] = tx;
            if (dcnt == 38) begin
                if (tx !== 1'b1) frame_err++;
                dec_bytes.push_back(dshift);
                dbusy = 1'b0;
            end
        end
        if (!rst && done === 1'b1) done_cnt++;
    end

    // Run-length recorder of the TX line, used to confirm bit widths.
    int   runs[$];
    int   run_len;
    logic run_lvl;

    always @(negedge clk) begin
        if (tx !== run_lvl) begin
            runs.push_back(run_len);
            run_lvl = tx;
            run_len = 1;
        end else run_len++;
    end

    task automatic clear_logs();
        @(posedge clk);
        dec_bytes.delete();
        addr_log.delete();
        runs.delete();
        run_len   = 0;
        run_lvl   = 1'b1;
        done_cnt  = 0;
        frame_err = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit seen, output logic a_now,
                             output logic a_prev);
        logic prev;
        seen   = 1'b0;
        a_now  = 1'bx;
        a_prev = 1'bx;
        prev   = active;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen   = 1'b1;
                a_now  = active;
                a_prev = prev;
                break;
            end
            prev = active;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int ph = 0; ph < 2; ph++) begin
            n_cmp++; if (tx !== 1'b1) begin n_fail++;
                $display("FAIL reset_tx ph%0d: got %b want 1", ph, tx); end
            n_cmp++; if (bus.rd_enable !== 1'b0) begin n_fail++;
                $display("FAIL reset_rd_enable ph%0d: got %b want 0", ph, bus.rd_enable); end
            n_cmp++; if (active !== 1'b0) begin n_fail++;
                $display("FAIL reset_active ph%0d: got %b want 0", ph, active); end
            n_cmp++; if (done !== 1'b0) begin n_fail++;
                $display("FAIL reset_done ph%0d: got %b want 0", ph, done); end
            n_cmp++; if (bus.rd_addr !== 24'd5) begin n_fail++;
                $display("FAIL reset_rd_addr ph%0d: got %0d want 5", ph, bus.rd_addr); end
            if (ph == 0) begin
                rst = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
    endtask

    task automatic test_single();
        bit   seen;
        logic a_now, a_prev;
        int   exp_runs[7] = '{8, 4, 4, 8, 4, 4, 4};
        clear_logs();
        pulse_start();
        n_cmp++; if (active !== 1'b0 || bus.rd_enable !== 1'b0) begin n_fail++;
            $display("FAIL start_latency_early: active=%b rd_enable=%b want 0/0",
                     active, bus.rd_enable); end
        @(negedge clk);
        n_cmp++; if (active !== 1'b1 || bus.rd_enable !== 1'b1) begin n_fail++;
            $display("FAIL start_latency: active=%b rd_enable=%b want 1/1", active, bus.rd_enable); end
        n_cmp++; if (bus.rd_addr !== 24'd5) begin n_fail++;
            $display("FAIL first_rd_addr: got %0d want 5", bus.rd_addr); end
        wait_done(2000, seen, a_now, a_prev);
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL single_done_timeout: got none want 1"); end
        n_cmp++; if (a_now !== 1'b0 || a_prev !== 1'b1) begin n_fail++;
            $display("FAIL active_fall: at done %b before %b want 0/1", a_now, a_prev); end
        repeat (5) @(negedge clk);
        n_cmp++; if (dec_bytes.size() != NBytes) begin n_fail++;
            $display("FAIL single_byte_count: got %0d want %0d", dec_bytes.size(), NBytes); end
        for (int i = 0; i < NBytes && i < dec_bytes.size(); i++) begin
            n_cmp++; if (dec_bytes[i] !== exp_bytes[i]) begin n_fail++;
                $display("FAIL single_byte%0d: got %h want %h", i, dec_bytes[i], exp_bytes[i]); end
        end
        n_cmp++; if (addr_log.size() != 3) begin n_fail++;
            $display("FAIL single_addr_count: got %0d want 3", addr_log.size()); end
        for (int i = 0; i < 3 && i < addr_log.size(); i++) begin
            n_cmp++; if (addr_log[i] != 5 + i) begin n_fail++;
                $display("FAIL single_addr%0d: got %0d want %0d", i, addr_log[i], 5 + i); end
        end
        n_cmp++; if (done_cnt != 1) begin n_fail++;
            $display("FAIL single_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (frame_err != 0) begin n_fail++;
            $display("FAIL single_framing: got %0d errors want 0", frame_err); end
        n_cmp++; if (runs.size() < 8) begin n_fail++;
            $display("FAIL bit_runs_count: got %0d want >=8", runs.size()); end
        else for (int i = 0; i < 7; i++) begin
            n_cmp++; if (runs[i+1] != exp_runs[i]) begin n_fail++;
                $display("FAIL bit_width_run%0d: got %0d want %0d", i, runs[i+1], exp_runs[i]); end
        end
    endtask

    task automatic test_start_ignored();
        bit   seen;
        logic a_now, a_prev;
        clear_logs();
        pulse_start();
        repeat (60) @(negedge clk);
        pulse_start();
        wait_done(2000, seen, a_now, a_prev);
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL ignored_done_timeout: got none want 1"); end
        repeat (150) @(negedge clk);
        n_cmp++; if (dec_bytes.size() != NBytes) begin n_fail++;
            $display("FAIL ignored_byte_count: got %0d want %0d", dec_bytes.size(), NBytes); end
        n_cmp++; if (done_cnt != 1) begin n_fail++;
            $display("FAIL ignored_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (addr_log.size() != 3) begin n_fail++;
            $display("FAIL ignored_addr_count: got %0d want 3", addr_log.size()); end
        n_cmp++; if (active !== 1'b0) begin n_fail++;
            $display("FAIL ignored_active_idle: got %b want 0", active); end
    endtask

    task automatic test_reset_mid();
        bit   found = 1'b0;
        bit   seen;
        logic a_now, a_prev;
        clear_logs();
        pulse_start();
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (dec_bytes.size() == 1 && dbusy && dcnt == 18) begin found = 1'b1; break; end
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL midreset_reach_bit3: got none want 1"); end
        n_cmp++; if (tx !== 1'b0) begin n_fail++;
            $display("FAIL midreset_tx_before: got %b want 0", tx); end
        rst = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_fail++;
            $display("FAIL midreset_tx_immediate: got %b want 1", tx); end
        n_cmp++; if (active !== 1'b0 || bus.rd_enable !== 1'b0) begin n_fail++;
            $display("FAIL midreset_outputs: active=%b rd_enable=%b want 0/0",
                     active, bus.rd_enable); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        repeat (60) @(negedge clk);
        n_cmp++; if (dec_bytes.size() != 0 || tx !== 1'b1) begin n_fail++;
            $display("FAIL midreset_no_partial: bytes=%0d tx=%b want 0/1", dec_bytes.size(), tx); end
        pulse_start();
        wait_done(2000, seen, a_now, a_prev);
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL restart_done_timeout: got none want 1"); end
        repeat (5) @(negedge clk);
        n_cmp++; if (addr_log.size() == 0 || addr_log[0] != 5) begin n_fail++;
            $display("FAIL restart_addr: got %0d want 5",
                     addr_log.size() == 0 ? -1 : addr_log[0]); end
        n_cmp++; if (dec_bytes.size() == 0 || dec_bytes[0] !== 8'h5A) begin n_fail++;
            $display("FAIL restart_first_byte: got %h want 5a",
                     dec_bytes.size() == 0 ? 8'hxx : dec_bytes[0]); end
        n_cmp++; if (dec_bytes.size() != NBytes) begin n_fail++;
            $display("FAIL restart_byte_count: got %0d want %0d", dec_bytes.size(), NBytes); end
    endtask

    task automatic test_wrap();
        bit seen = 1'b0;
        int exp_w[3] = '{6, 7, 0};
        @(posedge clk);
        addr_log_w.delete();
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done_w === 1'b1) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL wrap_done_timeout: got none want 1"); end
        n_cmp++; if (addr_log_w.size() != 3) begin n_fail++;
            $display("FAIL wrap_addr_count: got %0d want 3", addr_log_w.size()); end
        for (int i = 0; i < 3 && i < addr_log_w.size(); i++) begin
            n_cmp++; if (addr_log_w[i] != exp_w[i]) begin n_fail++;
                $display("FAIL wrap_addr%0d: got %0d want %0d", i, addr_log_w[i], exp_w[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_start_ignored();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
